// File: rtl/bitserial_mac_readout_if.sv
// Beat-input and result-output bundle for bitserial_mac_readout.
// Valid/ready: a transfer occurs on a rising clk edge where valid && ready; the sender holds payload stable while valid && !ready.
interface bitserial_mac_readout_if #(
  parameter int CHANNELS = 10,
  parameter int OUT_W    = 4
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS-1:0]       in_pos;
  logic [CHANNELS-1:0]       in_neg;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*OUT_W-1:0] out_data;
  logic [CHANNELS-1:0]       out_sat;

  modport master (
    output flush, in_valid, in_pos, in_neg, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  flush, in_valid, in_pos, in_neg, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/bitserial_mac_readout.sv
// Per-channel bit-serial pos/neg accumulation, difference, ReLU, rescale and saturation into one result word.
// Optional macro PIM_SIGNED_OUT_EN: two's-complement output clamped in both directions instead of ReLU.
module bitserial_mac_readout #(
  parameter int CHANNELS = 10,
  parameter int KERNEL   = 3,
  parameter int BITS     = 6,
  parameter int OUT_W    = 4,
  parameter int RSHIFT   = 0
) (
  input logic                   clk,
  input logic                   rst,
  bitserial_mac_readout_if.slave bus
);
  localparam int PS_W  = $clog2(KERNEL + 1);
  localparam int ACC_W = PS_W + BITS;
  localparam int BC_W  = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int PC_W  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BC_W-1:0] BEAT_LAST  = BC_W'(KERNEL - 1);
  localparam logic [PC_W-1:0] PLANE_LAST = PC_W'(BITS - 1);
`ifdef PIM_SIGNED_OUT_EN
  localparam logic signed [ACC_W:0] RES_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] RES_MIN = (ACC_W+1)'(-(1 << (OUT_W - 1)));
  localparam logic                  LOW_SAT = 1'b1;
`else
  localparam logic signed [ACC_W:0] RES_MAX = (ACC_W+1)'((1 << OUT_W) - 1);
  localparam logic signed [ACC_W:0] RES_MIN = '0;
  localparam logic                  LOW_SAT = 1'b0;
`endif

  logic [BC_W-1:0]           beat_cnt;
  logic [PC_W-1:0]           plane_cnt;
  logic                      plane_end;
  logic                      frame_end;
  logic                      accept;
  logic                      done;
  logic [CHANNELS*OUT_W-1:0] res_data;
  logic [CHANNELS-1:0]       res_sat;

  assign plane_end    = (beat_cnt == BEAT_LAST);
  assign frame_end    = plane_end && (plane_cnt == PLANE_LAST);
  // Only the closing beat of a frame waits for the output buffer to free up.
  assign bus.in_ready = !(frame_end && bus.out_valid && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign done         = accept && frame_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt  <= '0;
      plane_cnt <= '0;
    end else if (bus.flush || done) begin
      beat_cnt  <= '0;
      plane_cnt <= '0;
    end else if (accept) begin
      if (plane_end) begin
        beat_cnt  <= '0;
        plane_cnt <= plane_cnt + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PS_W-1:0]         ps_pos, ps_neg;
    logic [ACC_W-1:0]        acc_pos, acc_neg;
    logic [ACC_W-1:0]        acc_pos_nx, acc_neg_nx;
    logic signed [ACC_W:0]   diff, scaled;
    logic [OUT_W-1:0]        res_d;
    logic                    res_s;

    // The current beat's bit joins the plane sum in the same step as the shift-accumulate.
    assign acc_pos_nx = {acc_pos[ACC_W-2:0], 1'b0} + ACC_W'(ps_pos) + ACC_W'(bus.in_pos[c]);
    assign acc_neg_nx = {acc_neg[ACC_W-2:0], 1'b0} + ACC_W'(ps_neg) + ACC_W'(bus.in_neg[c]);
    assign diff       = $signed({1'b0, acc_pos_nx}) - $signed({1'b0, acc_neg_nx});
    assign scaled     = diff >>> RSHIFT;

    always_comb begin
      res_d = scaled[OUT_W-1:0];
      res_s = 1'b0;
      if (scaled > RES_MAX) begin
        res_d = RES_MAX[OUT_W-1:0];
        res_s = 1'b1;
      end else if (scaled < RES_MIN) begin
        res_d = RES_MIN[OUT_W-1:0];
        res_s = LOW_SAT;
      end
    end

    assign res_data[c*OUT_W +: OUT_W] = res_d;
    assign res_sat[c]                 = res_s;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ps_pos  <= '0;
        ps_neg  <= '0;
        acc_pos <= '0;
        acc_neg <= '0;
      end else if (bus.flush || done) begin
        ps_pos  <= '0;
        ps_neg  <= '0;
        acc_pos <= '0;
        acc_neg <= '0;
      end else if (accept) begin
        if (plane_end) begin
          ps_pos  <= '0;
          ps_neg  <= '0;
          acc_pos <= acc_pos_nx;
          acc_neg <= acc_neg_nx;
        end else begin
          ps_pos <= ps_pos + PS_W'(bus.in_pos[c]);
          ps_neg <= ps_neg + PS_W'(bus.in_neg[c]);
        end
      end
    end
  end

  // A completing frame overwrites the buffer; this also covers a same-cycle handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= '0;
    end else if (done) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= res_data;
      bus.out_sat   <= res_sat;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bitserial_mac_readout.sv
// Randomized scoreboard bench for bitserial_mac_readout with an arithmetic per-frame reference model.
module tb_bitserial_mac_readout;
  localparam int CH    = 10;
  localparam int K     = 3;
  localparam int B     = 6;
  localparam int OW    = 4;
  localparam int RS    = 0;
  localparam int FRAME = K * B;
  localparam int EW    = CH + CH * OW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bitserial_mac_readout_if #(.CHANNELS(CH), .OUT_W(OW)) bus ();

  bitserial_mac_readout #(
    .CHANNELS(CH), .KERNEL(K), .BITS(B), .OUT_W(OW), .RSHIFT(RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [CH-1:0] fr_pos[FRAME];
  logic [CH-1:0] fr_neg[FRAME];
  int            stall_cnt[FRAME];
  int            ready_mode = 0;
  int            frame_tag = 0;
  bit            f2_b16_done = 1'b0;
  bit            gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame value per channel = sum over beats of bit * 2^(significance of its plane).
  function automatic logic [EW-1:0] model();
    logic [CH-1:0]    sat;
    logic [CH*OW-1:0] data;
    logic [31:0]      v;
    int p, n, d, lo, hi;
    sat  = '0;
    data = '0;
`ifdef PIM_SIGNED_OUT_EN
    lo = -(1 << (OW - 1));
    hi = (1 << (OW - 1)) - 1;
`else
    lo = 0;
    hi = (1 << OW) - 1;
`endif
    for (int c = 0; c < CH; c++) begin
      p = 0;
      n = 0;
      for (int b = 0; b < FRAME; b++) begin
        if (fr_pos[b][c]) p += 1 << (B - 1 - b / K);
        if (fr_neg[b][c]) n += 1 << (B - 1 - b / K);
      end
      d = (p - n) >>> RS;
      if (d > hi) begin
        d = hi;
        sat[c] = 1'b1;
      end else if (d < lo) begin
`ifdef PIM_SIGNED_OUT_EN
        sat[c] = 1'b1;
`endif
        d = lo;
      end
      v = d;
      data[c*OW +: OW] = v[OW-1:0];
    end
    return {sat, data};
  endfunction

  task automatic clear_frame();
    for (int b = 0; b < FRAME; b++) begin
      fr_pos[b] = '0;
      fr_neg[b] = '0;
    end
  endtask

  task automatic rand_frame();
    int m;
    m = $urandom_range(0, 3);
    for (int b = 0; b < FRAME; b++) begin
      case (m)
        0: begin fr_pos[b] = CH'($urandom & $urandom); fr_neg[b] = CH'($urandom & $urandom); end
        1: begin fr_pos[b] = CH'($urandom); fr_neg[b] = CH'($urandom & $urandom & $urandom); end
        2: begin fr_pos[b] = CH'($urandom & $urandom & $urandom); fr_neg[b] = CH'($urandom); end
        default: begin
          fr_pos[b] = CH'($urandom & $urandom & $urandom & $urandom);
          fr_neg[b] = CH'($urandom & $urandom & $urandom & $urandom & $urandom);
        end
      endcase
    end
  endtask

  // Called at a negedge; returns at a negedge after the beat is accepted.
  task automatic drive_beat(input int b, input logic [EW-1:0] expv, input bit chk_rise);
    int stalls;
    int g;
    bit rdy;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_pos   = fr_pos[b];
    bus.in_neg   = fr_neg[b];
    forever begin
      #1;
      rdy = bus.in_ready;
      if (chk_rise && b == FRAME - 1) check("out_valid_before_last", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      if (rdy) break;
      stalls++;
      if (stalls > 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_ready_timeout: beat %0d stalled %0d cycles, required acceptance", b, stalls);
        break;
      end
      @(negedge clk);
    end
    stall_cnt[b] = stalls;
    if (b == FRAME - 1 && rdy) begin
      exp_q.push_back(expv);
      #1 check("out_valid_after_last", 64'(bus.out_valid), 64'd1);
    end
    if (frame_tag == 2 && b == FRAME - 2) f2_b16_done = 1'b1;
    @(negedge clk);
    if (gaps) begin
      g = $urandom_range(0, 2);
      if (g > 0) begin
        bus.in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input bit chk_rise);
    logic [EW-1:0] e;
    e = model();
    for (int b = 0; b < FRAME; b++) drive_beat(b, e, chk_rise);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got %0h with no frame pending", {bus.out_sat, bus.out_data});
      end else begin
        check("out_word", 64'({bus.out_sat, bus.out_data}), 64'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pos   = '0;
    bus.in_neg   = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_data",  64'(bus.out_data),  64'd0);
    check("reset_out_sat",   64'(bus.out_sat),   64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single plane-5 weight on ch0, then ReLU case on ch1, then overflow on ch2.
    clear_frame();
    for (int k = 0; k < K; k++) fr_pos[5*K + k][0] = 1'b1;
    send_frame(1'b1);
    clear_frame();
    fr_pos[4*K][1] = 1'b1;
    for (int k = 0; k < K; k++) fr_neg[4*K + k][1] = 1'b1;
    send_frame(1'b0);
    clear_frame();
    fr_pos[0][2] = 1'b1;
    send_frame(1'b0);
    drain("drain_directed");

    // Back-to-back frames with the consumer stalled until after frame 2's beat 17.
    ready_mode  = 2;
    f2_b16_done = 1'b0;
    repeat (2) @(negedge clk);
    fork
      begin
        rand_frame();
        frame_tag = 1;
        send_frame(1'b0);
        rand_frame();
        frame_tag = 2;
        send_frame(1'b0);
        frame_tag = 0;
      end
      begin
        for (int i = 0; i < 1000 && !f2_b16_done; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        ready_mode = 0;
      end
    join
    for (int b = 0; b < FRAME - 1; b++) check("stall_early_beat", 64'(stall_cnt[b]), 64'd0);
    check("stall_last_beat", 64'(stall_cnt[FRAME-1] > 0), 64'd1);
    drain("drain_backpressure");

    // Flush in place of beat 9, then a clean frame.
    clear_frame();
    for (int b = 0; b < FRAME; b++) fr_pos[b][0] = 1'b1;
    for (int b = 0; b < 8; b++) drive_beat(b, '0, 1'b0);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.in_pos   = fr_pos[8];
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    clear_frame();
    for (int k = 0; k < K; k++) fr_pos[5*K + k][0] = 1'b1;
    send_frame(1'b0);
    drain("drain_flush");

    // Reset mid-frame while a finished result is still held.
    ready_mode = 2;
    repeat (2) @(negedge clk);
    rand_frame();
    send_frame(1'b0);
    rand_frame();
    for (int b = 0; b < 12; b++) drive_beat(b, '0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_out_data",  64'(bus.out_data),  64'd0);
    check("midreset_out_sat",   64'(bus.out_sat),   64'd0);
    check("midreset_in_ready",  64'(bus.in_ready),  64'd1);
    ready_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_frame();
    fr_pos[0][2] = 1'b1;
    send_frame(1'b0);
    drain("drain_reset");

    // Random frames with idle gaps and random consumer backpressure.
    gaps       = 1'b1;
    ready_mode = 1;
    for (int f = 0; f < 30; f++) begin
      rand_frame();
      send_frame(1'b0);
    end
    gaps       = 1'b0;
    ready_mode = 0;
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
